// File: rtl/stopwatch_core.sv
// BCD MM:SS stopwatch/timer core: up/down count on tick, run/pause, field adjust, zero-latency outputs.
// Optional lap freeze is built only when STOPWATCH_LAP_EN is defined; otherwise frozen is tied low.
module stopwatch_core #(
    parameter int MIN_TEN_MAX = 9,
    parameter bit START_RUN   = 1'b0
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       tick,
    input  logic       adj_tick,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    input  logic       dir,
    input  logic       lap_p,
    output logic [3:0] min_ten,
    output logic [3:0] min_unit,
    output logic [2:0] sec_ten,
    output logic [3:0] sec_unit,
    output logic       running,
    output logic       frozen,
    output logic       wrap,
    output logic       done
);

    localparam logic [3:0] MT_MAX = 4'(MIN_TEN_MAX);

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
    } time_t;

    typedef enum logic [1:0] {
        MODE_PAUSE,
        MODE_RUN,
        MODE_ADJ
    } mode_t;

    time_t cnt, cnt_next;
    logic  run_next, wrap_next, done_next;
    mode_t mode;

    function automatic time_t inc_min(input time_t t);
        time_t r;
        r = t;
        if (t.mu == 4'd9) begin
            r.mu = 4'd0;
            r.mt = (t.mt == MT_MAX) ? 4'd0 : t.mt + 4'd1;
        end else begin
            r.mu = t.mu + 4'd1;
        end
        return r;
    endfunction

    function automatic time_t inc_sec(input time_t t);
        time_t r;
        r = t;
        if (t.su == 4'd9) begin
            r.su = 4'd0;
            r.st = (t.st == 3'd5) ? 3'd0 : t.st + 3'd1;
        end else begin
            r.su = t.su + 4'd1;
        end
        return r;
    endfunction

    function automatic logic sec_at_max(input time_t t);
        return (t.st == 3'd5) && (t.su == 4'd9);
    endfunction

    function automatic logic is_max(input time_t t);
        return (t.mt == MT_MAX) && (t.mu == 4'd9) && sec_at_max(t);
    endfunction

    function automatic logic is_zero(input time_t t);
        return (t.mt == 4'd0) && (t.mu == 4'd0) && (t.st == 3'd0) && (t.su == 4'd0);
    endfunction

    function automatic logic is_one(input time_t t);
        return (t.mt == 4'd0) && (t.mu == 4'd0) && (t.st == 3'd0) && (t.su == 4'd1);
    endfunction

    // Seconds carry feeds the minute field; callers handle the max->zero wrap.
    function automatic time_t inc_all(input time_t t);
        time_t r;
        r = inc_sec(t);
        if (sec_at_max(t)) begin
            r = inc_min(r);
        end
        return r;
    endfunction

    // Only called on a non-zero count, so a full borrow chain always finds mt > 0.
    function automatic time_t dec_all(input time_t t);
        time_t r;
        r = t;
        if (t.su != 4'd0) begin
            r.su = t.su - 4'd1;
        end else begin
            r.su = 4'd9;
            if (t.st != 3'd0) begin
                r.st = t.st - 3'd1;
            end else begin
                r.st = 3'd5;
                if (t.mu != 4'd0) begin
                    r.mu = t.mu - 4'd1;
                end else begin
                    r.mu = 4'd9;
                    r.mt = t.mt - 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        mode = MODE_PAUSE;
        if (adj) begin
            mode = MODE_ADJ;
        end else if (running) begin
            mode = MODE_RUN;
        end
    end

    always_comb begin
        cnt_next  = cnt;
        run_next  = running;
        wrap_next = 1'b0;
        done_next = 1'b0;
        case (mode)
            MODE_ADJ: begin
                if (adj_tick) begin
                    cnt_next = sel ? inc_sec(cnt) : inc_min(cnt);
                end
            end
            MODE_RUN: begin
                if (pause_p) begin
                    run_next = 1'b0;
                end
                if (tick) begin
                    if (!dir) begin
                        if (is_max(cnt)) begin
                            cnt_next  = '0;
                            wrap_next = 1'b1;
                        end else begin
                            cnt_next = inc_all(cnt);
                        end
                    end else if (is_zero(cnt)) begin
                        run_next = 1'b0;
                    end else begin
                        // Reaching zero stops the timer even if a pause toggle coincides.
                        cnt_next = dec_all(cnt);
                        if (is_one(cnt)) begin
                            done_next = 1'b1;
                            run_next  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                if (pause_p) begin
                    run_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            running <= START_RUN;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            running <= run_next;
            wrap    <= wrap_next;
            done    <= done_next;
        end
    end

`ifdef STOPWATCH_LAP_EN
    time_t lap;

    // Capture uses the pre-tick count, so a coincident tick is not reflected in the lap.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            lap    <= '0;
            frozen <= 1'b0;
        end else if (adj) begin
            frozen <= 1'b0;
        end else if (lap_p) begin
            frozen <= ~frozen;
            if (!frozen) begin
                lap <= cnt;
            end
        end
    end

    assign min_ten  = frozen ? lap.mt : cnt.mt;
    assign min_unit = frozen ? lap.mu : cnt.mu;
    assign sec_ten  = frozen ? lap.st : cnt.st;
    assign sec_unit = frozen ? lap.su : cnt.su;
`else
    logic unused_lap_p;
    assign unused_lap_p = lap_p;

    assign frozen   = 1'b0;
    assign min_ten  = cnt.mt;
    assign min_unit = cnt.mu;
    assign sec_ten  = cnt.st;
    assign sec_unit = cnt.su;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random traffic against a seconds-count model.
module tb_stopwatch_core;

    localparam int MTM   = 9;
    localparam bit SR    = 1'b0;
    localparam int NMIN  = MTM * 10 + 10;
    localparam int TOTAL = NMIN * 60;

    logic       clock, rst;
    logic       tick, adj_tick, pause_p, adj, sel, dir, lap_p;
    logic [3:0] min_ten, min_unit, sec_unit;
    logic [2:0] sec_ten;
    logic       running, frozen, wrap, done;

    stopwatch_core #(.MIN_TEN_MAX(MTM), .START_RUN(SR)) dut (
        .clock    (clock),
        .rst      (rst),
        .tick     (tick),
        .adj_tick (adj_tick),
        .pause_p  (pause_p),
        .adj      (adj),
        .sel      (sel),
        .dir      (dir),
        .lap_p    (lap_p),
        .min_ten  (min_ten),
        .min_unit (min_unit),
        .sec_ten  (sec_ten),
        .sec_unit (sec_unit),
        .running  (running),
        .frozen   (frozen),
        .wrap     (wrap),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: the count is plain elapsed seconds.
    int m_secs, m_lap;
    bit m_run, m_frozen, m_wrap, m_done;

    function automatic logic [31:0] disp_of(input int s);
        int m;
        m = s / 60;
        return 32'(((m / 10) << 11) | ((m % 10) << 7) | (((s % 60) / 10) << 4) | (s % 10));
    endfunction

    function automatic logic [31:0] disp_obs();
        return {17'd0, min_ten, min_unit, sec_ten, sec_unit};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_lap = 0; m_run = SR; m_frozen = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_clk();
        bit was_run;
        m_wrap = 0;
        m_done = 0;
        if (adj) begin
            if (adj_tick) begin
                if (sel) m_secs = (m_secs / 60) * 60 + (m_secs % 60 + 1) % 60;
                else     m_secs = ((m_secs / 60 + 1) % NMIN) * 60 + m_secs % 60;
            end
            m_frozen = 0;
        end else begin
            was_run = m_run;
`ifdef STOPWATCH_LAP_EN
            if (lap_p) begin
                if (!m_frozen) m_lap = m_secs;
                m_frozen = !m_frozen;
            end
`endif
            if (pause_p) m_run = !m_run;
            if (was_run && tick) begin
                if (!dir) begin
                    if (m_secs == TOTAL - 1) begin
                        m_secs = 0;
                        m_wrap = 1;
                    end else begin
                        m_secs++;
                    end
                end else if (m_secs == 0) begin
                    m_run = 0;
                end else begin
                    m_secs--;
                    if (m_secs == 0) begin
                        m_done = 1;
                        m_run  = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".disp"}, disp_obs(), disp_of(m_frozen ? m_lap : m_secs));
        chk({tag, ".running"}, 32'(running), 32'(m_run));
        chk({tag, ".frozen"}, 32'(frozen), 32'(m_frozen));
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    task automatic step(input bit t, input bit at, input bit pp, input bit lp);
        tick = t; adj_tick = at; pause_p = pp; lap_p = lp;
        @(posedge clock);
        model_clk();
        #1;
        check_all("step");
        tick = 0; adj_tick = 0; pause_p = 0; lap_p = 0;
    endtask

    task automatic goto_time(input int m, input int s);
        adj = 1; sel = 0;
        for (int i = 0; i < 200 && (m_secs / 60) != m; i++) step(0, 1, 0, 0);
        sel = 1;
        for (int i = 0; i < 100 && (m_secs % 60) != s; i++) step(0, 1, 0, 0);
        chk("goto", disp_obs(), disp_of(m * 60 + s));
    endtask

    task automatic leave_adj();
        adj = 0;
        step(0, 0, 0, 0);
    endtask

    task automatic set_run(input bit r);
        if (m_run != r) step(0, 0, 1, 0);
        chk("set_run", 32'(running), 32'(r));
    endtask

    initial begin
        tick = 0; adj_tick = 0; pause_p = 0; adj = 0; sel = 0; dir = 0; lap_p = 0;
        rst = 1;
        model_reset();
        #12;
        chk("reset.disp", disp_obs(), 32'd0);
        chk("reset.running", 32'(running), 32'(SR));
        chk("reset.frozen", 32'(frozen), 32'd0);
        chk("reset.wrap_done", 32'({wrap, done}), 32'd0);
        rst = 0;
        #10;

        // Paused: ticks ignored; then run 61 ticks.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        chk("paused.disp", disp_obs(), disp_of(0));
        chk("paused.running", 32'(running), 32'd0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 61; i++) step(1, 0, 0, 0);
        chk("run61", disp_obs(), disp_of(61));

        // Up-count wrap at the top of the range.
        goto_time(99, 58);
        leave_adj();
        set_run(1);
        dir = 0;
        step(1, 0, 0, 0);
        chk("wrap.9959", disp_obs(), disp_of(99 * 60 + 59));
        chk("wrap.lowbefore", 32'(wrap), 32'd0);
        step(1, 0, 0, 0);
        chk("wrap.0000", disp_obs(), disp_of(0));
        chk("wrap.pulse", 32'(wrap), 32'd1);
        step(0, 0, 0, 0);
        chk("wrap.oneshot", 32'(wrap), 32'd0);

        // Down-count to zero.
        goto_time(0, 3);
        leave_adj();
        dir = 1;
        set_run(1);
        step(1, 0, 0, 0);
        chk("down.0002", disp_obs(), disp_of(2));
        step(1, 0, 0, 0);
        chk("down.0001", disp_obs(), disp_of(1));
        step(1, 0, 0, 0);
        chk("down.0000", disp_obs(), disp_of(0));
        chk("down.done", 32'(done), 32'd1);
        chk("down.stopped", 32'(running), 32'd0);
        step(1, 0, 0, 0);
        chk("down.extra", disp_obs(), disp_of(0));
        chk("down.nodone", 32'(done), 32'd0);

        // Seconds adjust wraps without carry; minutes adjust wraps 99->00.
        goto_time(0, 58);
        step(0, 1, 0, 0);
        chk("adjs.0059", disp_obs(), disp_of(59));
        step(0, 1, 0, 0);
        chk("adjs.0000", disp_obs(), disp_of(0));
        step(0, 1, 0, 0);
        chk("adjs.0001", disp_obs(), disp_of(1));
        goto_time(99, 1);
        sel = 0;
        step(0, 1, 0, 0);
        chk("adjm.wrap", disp_obs(), disp_of(1));

        // Coincident tick and pause while running.
        goto_time(0, 10);
        leave_adj();
        dir = 0;
        set_run(1);
        step(1, 0, 1, 0);
        chk("tickpause.disp", disp_obs(), disp_of(11));
        chk("tickpause.running", 32'(running), 32'd0);

        // Lap freeze.
        goto_time(0, 20);
        leave_adj();
        set_run(1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
`ifdef STOPWATCH_LAP_EN
        chk("lap.held", disp_obs(), disp_of(20));
        chk("lap.frozen", 32'(frozen), 32'd1);
`else
        chk("lap.live", disp_obs(), disp_of(25));
        chk("lap.frozen", 32'(frozen), 32'd0);
`endif
        step(0, 0, 0, 1);
        chk("lap.release", disp_obs(), disp_of(25));
        chk("lap.unfrozen", 32'(frozen), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0)  sel = ~sel;
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0);
        end

        // Asynchronous reset mid-count, away from any clock edge.
        adj = 0;
        goto_time(42, 17);
        leave_adj();
        #2;
        rst = 1;
        #1;
        chk("areset.disp", disp_obs(), 32'd0);
        chk("areset.running", 32'(running), 32'(SR));
        chk("areset.frozen", 32'(frozen), 32'd0);
        chk("areset.wrap_done", 32'({wrap, done}), 32'd0);
        model_reset();
        #10;
        rst = 0;
        sel = 0; dir = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0)  sel = ~sel;
            if ($urandom_range(0, 29) == 0) dir = ~dir;
            step($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
